// File: rtl/subpel_vertical_filter.sv
`default_nettype none
// ============================================================================
// Module      : subpel_vertical_filter
// Description : HEVC 8-tap luma vertical filter (quarter/half/three-quarter)
//               over an 8-row sliding window of horizontally filtered rows.
// Revision    : 1.0 - initial release
// ============================================================================
module subpel_vertical_filter #(
  parameter int NUM_COL  = 8,
  parameter int PIX_W    = 8,
  parameter int OUT_ROWS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_COL*PIX_W-1:0] in_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_COL*PIX_W-1:0] out_a,
  output logic [NUM_COL*PIX_W-1:0] out_b,
  output logic [NUM_COL*PIX_W-1:0] out_c,
  output logic [3:0]               out_row_idx,
  output logic                     block_done
);

  localparam int c_row_w = NUM_COL * PIX_W;
  localparam int c_cnt_w = $clog2(OUT_ROWS + 7);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(7);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OUT_ROWS + 6);
  localparam logic [3:0]         c_idx_last = 4'(OUT_ROWS - 1);
  localparam logic signed [15:0] c_pix_max  = 16'((1 << PIX_W) - 1);

  // Coefficients packed tap7 (MSB) .. tap0 (LSB), two's complement bytes
  localparam logic [63:0] c_coef_a = {8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};
  localparam logic [63:0] c_coef_b = {8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
  localparam logic [63:0] c_coef_c = {8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_row_w-1:0]   r_hist [7];
  logic [c_cnt_w-1:0]   r_rcnt;
  logic                 w_accept;
  logic                 w_produce;
  logic                 w_last;
  logic                 w_out_hs;
  logic [c_row_w-1:0]   w_a;
  logic [c_row_w-1:0]   w_b;
  logic [c_row_w-1:0]   w_c;

  function automatic logic [PIX_W-1:0] fir(input logic [8*PIX_W-1:0] win,
                                           input logic [63:0] coef);
    logic signed [15:0] acc;
    logic signed [15:0] rnd;
    acc = '0;
    for (int t = 0; t < 8; t++) begin
      acc = acc + $signed({{8{coef[t*8+7]}}, coef[t*8 +: 8]})
                * $signed({{(16-PIX_W){1'b0}}, win[t*PIX_W +: PIX_W]});
    end
    rnd = (acc + 16'sd32) >>> 6;
    if (rnd < 16'sd0)
      fir = '0;
    else if (rnd > c_pix_max)
      fir = '1;
    else
      fir = rnd[PIX_W-1:0];
  endfunction

  // The incoming row is tap7 of the window used by the producing accept
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [8*PIX_W-1:0] w_win;
    always_comb begin
      for (int t = 0; t < 7; t++)
        w_win[t*PIX_W +: PIX_W] = r_hist[t][c*PIX_W +: PIX_W];
      w_win[7*PIX_W +: PIX_W] = in_row[c*PIX_W +: PIX_W];
    end
    assign w_a[c*PIX_W +: PIX_W] = fir(w_win, c_coef_a);
    assign w_b[c*PIX_W +: PIX_W] = fir(w_win, c_coef_b);
    assign w_c[c*PIX_W +: PIX_W] = fir(w_win, c_coef_c);
  end

  // FILL only stalls on the row that would overwrite a still-pending output
  assign in_ready   = !rst && !flush &&
                      ((r_state == ST_FILL && r_rcnt != c_cnt_full) || !out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_rcnt == c_cnt_last);
  assign w_produce  = w_accept && (r_state == ST_RUN || r_rcnt == c_cnt_full);
  assign w_out_hs   = out_valid && out_ready && !flush;
  assign block_done = w_out_hs && (out_row_idx == c_idx_last);

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FILL;
    end else if (w_accept) begin
      case (r_state)
        ST_FILL: if (r_rcnt == c_cnt_full) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last) w_state_nxt = ST_FILL;
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_rcnt  <= '0;
      for (int i = 0; i < 7; i++) r_hist[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_rcnt <= '0;
      end else if (w_accept) begin
        r_rcnt <= w_last ? '0 : r_rcnt + c_cnt_w'(1);
        for (int i = 0; i < 6; i++) r_hist[i] <= r_hist[i+1];
        r_hist[6] <= in_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_row_idx <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_row_idx <= '0;
    end else begin
      if (w_produce) begin
        out_valid <= 1'b1;
        out_a     <= w_a;
        out_b     <= w_b;
        out_c     <= w_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_out_hs)
        out_row_idx <= (out_row_idx == c_idx_last) ? 4'd0 : out_row_idx + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subpel_vertical_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_subpel_vertical_filter
// Description : Scoreboard bench for subpel_vertical_filter with a row-level
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subpel_vertical_filter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, block_done;
  logic [W-1:0] in_row, out_a, out_b, out_c;
  logic [3:0]   out_row_idx;

  always #5 clk = ~clk;

  subpel_vertical_filter #(.NUM_COL(8), .PIX_W(8), .OUT_ROWS(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_row_idx(out_row_idx), .block_done(block_done)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    int           idx;
  } exp_t;

  int           checks = 0, errors = 0;
  exp_t         exp_q[$];
  exp_t         e_new;
  logic [W-1:0] hist[$];
  int           blk_n = 0, exp_idx = 0, done_seen = 0;
  bit           lat_pending = 0;
  int           rdy_pct = 100, vld_pct = 100;
  int           ka[8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  int           kb[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  int           kc[8] = '{0, 1, -5, 17, 58, -10, 4, -1};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // hist[0] is the oldest row of the current 8-row window
  function automatic logic [W-1:0] ref_row(input int k[8]);
    logic [W-1:0] r;
    int s;
    r = '0;
    for (int col = 0; col < 8; col++) begin
      s = 0;
      for (int t = 0; t < 8; t++) s += k[t] * int'(hist[t][col*8 +: 8]);
      s = (s + 32) >>> 6;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      r[col*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input int v);
    return {8{8'(v)}};
  endfunction

  // Input side: model every accepted row and push the row it should yield
  always @(negedge clk) begin
    if (rst || flush) begin
      hist.delete();
      blk_n = 0;
      exp_idx = 0;
      lat_pending = 0;
    end else begin
      if (lat_pending) begin
        check("latency_out_valid", 64'(out_valid), 64'(1));
        lat_pending = 0;
      end
      if (in_valid && in_ready) begin
        hist.push_back(in_row);
        if (hist.size() > 8) void'(hist.pop_front());
        blk_n++;
        if (blk_n >= 8) begin
          e_new.a = ref_row(ka);
          e_new.b = ref_row(kb);
          e_new.c = ref_row(kc);
          e_new.idx = exp_idx;
          exp_idx = (exp_idx + 1) % 8;
          exp_q.push_back(e_new);
          lat_pending = 1;
        end
        if (blk_n == 15) begin
          blk_n = 0;
          hist.delete();
        end
      end
    end
  end

  // Output side: every presented row must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got row idx %0d, expected no output", out_row_idx);
      end else begin
        check("out_a", out_a, exp_q[0].a);
        check("out_b", out_b, exp_q[0].b);
        check("out_c", out_c, exp_q[0].c);
        check("out_row_idx", 64'(out_row_idx), 64'(exp_q[0].idx));
        if (out_ready && !flush) begin
          check("block_done", 64'(block_done), 64'(exp_q[0].idx == 7));
          if (block_done) done_seen++;
          void'(exp_q.pop_front());
        end
      end
    end
    if (rst || flush) exp_q.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic push_row(input logic [W-1:0] row);
    bit ok = 0;
    while ($urandom_range(0, 99) >= vld_pct) begin
      in_valid = 1'b0;
      in_row = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b1;
    in_row = row;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_row = {$urandom, $urandom};
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_a"}, out_a, 64'(0));
    check({tag, "_out_b"}, out_b, 64'(0));
    check({tag, "_out_c"}, out_c, 64'(0));
    check({tag, "_out_row_idx"}, 64'(out_row_idx), 64'(0));
    check({tag, "_block_done"}, 64'(block_done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic [W-1:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Constant, ramp and clipping blocks with a free-running consumer
    for (int k = 0; k < 15; k++) push_row(fill(100));
    idle(3);
    for (int k = 0; k < 15; k++) push_row(fill(10 * k));
    idle(3);
    for (int k = 0; k < 15; k++) push_row(k == 3 ? fill(255) : fill(0));
    idle(3);
    for (int k = 0; k < 15; k++) push_row((k == 2 || k == 5) ? fill(255) : fill(0));
    idle(3);

    // Backpressure in RUN
    for (int k = 0; k < 10; k++) push_row({$urandom, $urandom});
    r = {$urandom, $urandom};
    in_valid = 1'b1; in_row = r; out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push_row(r);
    for (int k = 11; k < 15; k++) push_row({$urandom, $urandom});
    idle(3);

    // Back-to-back blocks
    d0 = done_seen;
    for (int k = 0; k < 30; k++) push_row({$urandom, $urandom});
    idle(5);
    check("b2b_done_count", 64'(done_seen - d0), 64'(2));

    // Random valid/ready traffic
    rdy_pct = 60; vld_pct = 70;
    for (int k = 0; k < 60; k++) push_row({$urandom, $urandom});
    rdy_pct = 100; vld_pct = 100;
    idle(5);

    // Flush after 10 rows, then a fresh block
    for (int k = 0; k < 10; k++) push_row({$urandom, $urandom});
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 15; k++) push_row({$urandom, $urandom});
    idle(5);

    // Asynchronous reset mid-RUN, then a fresh block
    for (int k = 0; k < 10; k++) push_row({$urandom, $urandom});
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rdy_pct = 80;
    for (int k = 0; k < 15; k++) push_row({$urandom, $urandom});
    rdy_pct = 100;
    idle(20);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
